// File: rtl/fb_write_arbiter_if.sv
// Request and buffer-write signal bundle for fb_write_arbiter.
// The arbiter takes the slave modport; the requesters/buffer side take master.
interface fb_write_arbiter_if #(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 8
) ();
    logic          cam_we;
    logic [AW-1:0] cam_addr;
    logic [DW-1:0] cam_data;
    logic          drw_valid;
    logic          drw_ready;
    logic [AW-1:0] drw_addr;
    logic [DW-1:0] drw_data;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic          err_oob;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;

    modport master (
        output cam_we, cam_addr, cam_data, drw_valid, drw_addr, drw_data, clr_start, clr_color,
        input  drw_ready, clr_busy, clr_done, err_oob, addr_in, data_in, regwrite
    );

    modport slave (
        input  cam_we, cam_addr, cam_data, drw_valid, drw_addr, drw_data, clr_start, clr_color,
        output drw_ready, clr_busy, clr_done, err_oob, addr_in, data_in, regwrite
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: camera > clear engine > draw, registered write port.
// Optional FBW_BLANK_PROTECT_EN write-protects the blank pixel at address 2**AW-1.
module fb_write_arbiter #(
    parameter int unsigned AW   = 15,
    parameter int unsigned DW   = 8,
    parameter int unsigned NPIX = 19200
) (
    input logic               clk,
    input logic               rst,
    fb_write_arbiter_if.slave bus
);

    localparam logic [AW-1:0] LastAddr  = AW'(NPIX - 1);
    localparam logic [AW-1:0] BlankAddr = '1;

`ifdef FBW_BLANK_PROTECT_EN
    localparam bit BlankProtect = 1'b1;
`else
    localparam bit BlankProtect = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] color_q, color_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          drw_ready;
    logic          cam_blank, drw_blank;

    assign drw_ready = !bus.cam_we && (state_q == StIdle);
    assign cam_blank = BlankProtect && (bus.cam_addr == BlankAddr);
    assign drw_blank = BlankProtect && (bus.drw_addr == BlankAddr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        err_d   = err_q;

        // Write-port grant; dropped requests leave we_d low.
        if (bus.cam_we) begin
            if (cam_blank) begin
                we_d = 1'b0;
            end else if (bus.cam_addr > LastAddr) begin
                err_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                addr_d = bus.cam_addr;
                data_d = bus.cam_data;
            end
        end else if (state_q == StClear) begin
            we_d   = 1'b1;
            addr_d = cnt_q;
            data_d = color_q;
        end else if (bus.drw_valid && drw_ready) begin
            if (drw_blank) begin
                we_d = 1'b0;
            end else if (bus.drw_addr > LastAddr) begin
                err_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                addr_d = bus.drw_addr;
                data_d = bus.drw_data;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    color_d = bus.clr_color;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                // A camera cycle stalls the fill; cnt never passes LastAddr.
                if (!bus.cam_we) begin
                    if (cnt_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            color_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign bus.drw_ready = drw_ready;
    assign bus.clr_busy  = (state_q == StClear);
    assign bus.clr_done  = (state_q == StDone);
    assign bus.err_oob   = err_q;
    assign bus.addr_in   = addr_q;
    assign bus.data_in   = data_q;
    assign bus.regwrite  = we_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed self-checking bench for fb_write_arbiter (160x120, 8-bit pixels).
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_fb_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fb_write_arbiter_if #(.AW(15), .DW(8)) bus ();

    fb_write_arbiter #(
        .AW  (15),
        .DW  (8),
        .NPIX(19200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cam_we    = 1'b0;
        bus.cam_addr  = '0;
        bus.cam_data  = '0;
        bus.drw_valid = 1'b0;
        bus.drw_addr  = '0;
        bus.drw_data  = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.addr_in !== 15'd0) begin n_err++; $display("FAIL reset addr_in: got %0d want 0", bus.addr_in); end
        n_cmp++; if (bus.data_in !== 8'd0) begin n_err++; $display("FAIL reset data_in: got %0h want 0", bus.data_in); end
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL reset regwrite: got %b want 0", bus.regwrite); end
        n_cmp++; if (bus.clr_busy !== 1'b0) begin n_err++; $display("FAIL reset clr_busy: got %b want 0", bus.clr_busy); end
        n_cmp++; if (bus.clr_done !== 1'b0) begin n_err++; $display("FAIL reset clr_done: got %b want 0", bus.clr_done); end
        n_cmp++; if (bus.err_oob !== 1'b0) begin n_err++; $display("FAIL reset err_oob: got %b want 0", bus.err_oob); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b1) begin n_err++; $display("FAIL reset drw_ready: got %b want 1", bus.drw_ready); end
    endtask

    task automatic test_cam_burst();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + 8'(i);
            bus.cam_we    = 1'b1;
            bus.cam_addr  = 15'(i);
            bus.cam_data  = d;
            bus.drw_valid = 1'b1;
            bus.drw_addr  = 15'd300;
            #1;
            n_cmp++; if (bus.drw_ready !== 1'b0) begin n_err++; $display("FAIL cam drw_ready[%0d]: got %b want 0", i, bus.drw_ready); end
            tick();
            n_cmp++;
            if (bus.regwrite !== 1'b1 || bus.addr_in !== 15'(i) || bus.data_in !== d) begin
                n_err++;
                $display("FAIL cam write[%0d]: got we=%b addr=%0d data=%0h want we=1 addr=%0d data=%0h",
                         i, bus.regwrite, bus.addr_in, bus.data_in, i, d);
            end
        end
        idle_inputs();
        tick();
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL cam idle regwrite: got %b want 0", bus.regwrite); end
    endtask

    task automatic test_draw();
        bus.drw_valid = 1'b1;
        bus.drw_addr  = 15'd100;
        bus.drw_data  = 8'h5C;
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b1) begin n_err++; $display("FAIL draw ready: got %b want 1", bus.drw_ready); end
        tick();
        bus.drw_valid = 1'b0;
        n_cmp++;
        if (bus.regwrite !== 1'b1 || bus.addr_in !== 15'd100 || bus.data_in !== 8'h5C) begin
            n_err++;
            $display("FAIL draw write: got we=%b addr=%0d data=%0h want we=1 addr=100 data=5c",
                     bus.regwrite, bus.addr_in, bus.data_in);
        end
        tick();
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL draw idle regwrite: got %b want 0", bus.regwrite); end
    endtask

    task automatic test_clear_full();
        int exp_addr = 0;
        int bad = 0;
        int dones = 0;
        int done_at = -1;
        bus.clr_color = 8'h00;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        n_cmp++; if (bus.clr_busy !== 1'b1) begin n_err++; $display("FAIL clear busy: got %b want 1", bus.clr_busy); end
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL clear start regwrite: got %b want 0", bus.regwrite); end
        bus.drw_valid = 1'b1;
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b0) begin n_err++; $display("FAIL clear drw_ready: got %b want 0", bus.drw_ready); end
        bus.drw_valid = 1'b0;
        for (int k = 0; k < 19210 && dones == 0; k++) begin
            tick();
            if (bus.regwrite === 1'b1) begin
                if (bus.addr_in !== 15'(exp_addr) || bus.data_in !== 8'h00) bad++;
                exp_addr++;
            end
            if (bus.clr_done === 1'b1) begin
                dones++;
                done_at = exp_addr;
            end
        end
        n_cmp++; if (bus.clr_busy !== 1'b0) begin n_err++; $display("FAIL clear busy in done: got %b want 0", bus.clr_busy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.clr_done === 1'b1) dones++;
            if (bus.regwrite === 1'b1) bad++;
        end
        n_cmp++; if (exp_addr != 19200) begin n_err++; $display("FAIL clear write count: got %0d want 19200", exp_addr); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clear sequence: got %0d bad writes want 0", bad); end
        n_cmp++; if (dones != 1) begin n_err++; $display("FAIL clear done pulses: got %0d want 1", dones); end
        n_cmp++; if (done_at != 19200) begin n_err++; $display("FAIL clear done timing: got writes=%0d at done want 19200", done_at); end
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b1) begin n_err++; $display("FAIL clear after ready: got %b want 1", bus.drw_ready); end
    endtask

    task automatic test_clear_cam_stall();
        int exp_addr = 0;
        int fills = 0;
        int cam_bad = 0;
        int fill_bad = 0;
        int done_at = -1;
        bit done = 1'b0;
        bit cam_now;
        bus.clr_color = 8'h3C;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int k = 0; k < 30000 && !done; k++) begin
            cam_now      = (k % 3 == 0);
            bus.cam_we   = cam_now;
            bus.cam_addr = 15'(k % 19000);
            bus.cam_data = 8'h80 | 8'(k);
            tick();
            if (cam_now) begin
                if (bus.regwrite !== 1'b1 || bus.addr_in !== bus.cam_addr ||
                    bus.data_in !== bus.cam_data) cam_bad++;
            end else if (exp_addr < 19200) begin
                if (bus.regwrite !== 1'b1 || bus.addr_in !== 15'(exp_addr) ||
                    bus.data_in !== 8'h3C) fill_bad++;
                exp_addr++;
            end
            if (bus.regwrite === 1'b1 && bus.data_in === 8'h3C) fills++;
            if (bus.clr_done === 1'b1) begin
                done    = 1'b1;
                done_at = exp_addr;
            end
        end
        idle_inputs();
        tick();
        n_cmp++; if (cam_bad != 0) begin n_err++; $display("FAIL stall cam writes: got %0d bad want 0", cam_bad); end
        n_cmp++; if (fill_bad != 0) begin n_err++; $display("FAIL stall fill order: got %0d bad want 0", fill_bad); end
        n_cmp++; if (fills != 19200) begin n_err++; $display("FAIL stall fill count: got %0d want 19200", fills); end
        n_cmp++; if (done_at != 19200) begin n_err++; $display("FAIL stall done: got seen=%b at %0d want at 19200", done, done_at); end
        n_cmp++; if (bus.err_oob !== 1'b0) begin n_err++; $display("FAIL stall err_oob: got %b want 0", bus.err_oob); end
    endtask

    task automatic test_draw_and_start();
        bus.drw_valid = 1'b1;
        bus.drw_addr  = 15'd50;
        bus.drw_data  = 8'h99;
        bus.clr_start = 1'b1;
        bus.clr_color = 8'h11;
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b1) begin n_err++; $display("FAIL start+draw ready: got %b want 1", bus.drw_ready); end
        tick();
        bus.clr_start = 1'b0;
        #1;
        n_cmp++;
        if (bus.regwrite !== 1'b1 || bus.addr_in !== 15'd50 || bus.data_in !== 8'h99) begin
            n_err++;
            $display("FAIL start+draw write: got we=%b addr=%0d data=%0h want we=1 addr=50 data=99",
                     bus.regwrite, bus.addr_in, bus.data_in);
        end
        n_cmp++; if (bus.drw_ready !== 1'b0 || bus.clr_busy !== 1'b1) begin n_err++; $display("FAIL start+draw state: got ready=%b busy=%b want 0/1", bus.drw_ready, bus.clr_busy); end
        tick();
        n_cmp++;
        if (bus.regwrite !== 1'b1 || bus.addr_in !== 15'd0 || bus.data_in !== 8'h11) begin
            n_err++;
            $display("FAIL start+draw fill0: got we=%b addr=%0d data=%0h want we=1 addr=0 data=11",
                     bus.regwrite, bus.addr_in, bus.data_in);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_fill();
        int dones = 0;
        bus.clr_color = 8'h77;
        bus.clr_start = 1'b1;
        tick();
        for (int i = 1; i <= 5000; i++) begin
            bus.clr_start = (i == 101);
            bus.clr_color = (i == 101) ? 8'hEE : 8'h77;
            tick();
            if (i == 102) begin
                n_cmp++;
                if (bus.addr_in !== 15'd101 || bus.data_in !== 8'h77) begin
                    n_err++;
                    $display("FAIL restart ignored: got addr=%0d data=%0h want addr=101 data=77",
                             bus.addr_in, bus.data_in);
                end
            end
        end
        bus.clr_start = 1'b0;
        n_cmp++; if (bus.addr_in !== 15'd4999) begin n_err++; $display("FAIL midfill pos: got %0d want 4999", bus.addr_in); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.clr_busy !== 1'b0 || bus.regwrite !== 1'b0) begin n_err++; $display("FAIL midfill abort: got busy=%b we=%b want 0/0", bus.clr_busy, bus.regwrite); end
        for (int k = 0; k < 6; k++) begin
            if (bus.clr_done === 1'b1) dones++;
            tick();
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL midfill done: got %0d pulses want 0", dones); end
    endtask

    task automatic test_oob();
        bus.drw_valid = 1'b1;
        bus.drw_addr  = 15'd19199;
        bus.drw_data  = 8'h42;
        tick();
        n_cmp++;
        if (bus.regwrite !== 1'b1 || bus.addr_in !== 15'd19199 || bus.err_oob !== 1'b0) begin
            n_err++;
            $display("FAIL oob last pixel: got we=%b addr=%0d err=%b want 1/19199/0",
                     bus.regwrite, bus.addr_in, bus.err_oob);
        end
        bus.drw_addr = 15'd19200;
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b1) begin n_err++; $display("FAIL oob draw ready: got %b want 1", bus.drw_ready); end
        tick();
        bus.drw_valid = 1'b0;
        n_cmp++; if (bus.regwrite !== 1'b0 || bus.err_oob !== 1'b1) begin n_err++; $display("FAIL oob draw: got we=%b err=%b want 0/1", bus.regwrite, bus.err_oob); end
        tick();
        tick();
        n_cmp++; if (bus.err_oob !== 1'b1) begin n_err++; $display("FAIL oob sticky: got %b want 1", bus.err_oob); end
        pulse_reset();
        n_cmp++; if (bus.err_oob !== 1'b0) begin n_err++; $display("FAIL oob reset clear: got %b want 0", bus.err_oob); end
        bus.cam_we   = 1'b1;
        bus.cam_addr = 15'd20000;
        bus.cam_data = 8'h01;
        tick();
        bus.cam_we = 1'b0;
        n_cmp++; if (bus.regwrite !== 1'b0 || bus.err_oob !== 1'b1) begin n_err++; $display("FAIL oob cam: got we=%b err=%b want 0/1", bus.regwrite, bus.err_oob); end
        pulse_reset();
    endtask

    task automatic test_blank();
        logic exp_err;
`ifdef FBW_BLANK_PROTECT_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        bus.drw_valid = 1'b1;
        bus.drw_addr  = 15'h7FFF;
        bus.drw_data  = 8'hAB;
        #1;
        n_cmp++; if (bus.drw_ready !== 1'b1) begin n_err++; $display("FAIL blank ready: got %b want 1", bus.drw_ready); end
        tick();
        bus.drw_valid = 1'b0;
        n_cmp++; if (bus.regwrite !== 1'b0) begin n_err++; $display("FAIL blank write: got %b want 0", bus.regwrite); end
        n_cmp++; if (bus.err_oob !== exp_err) begin n_err++; $display("FAIL blank err_oob: got %b want %b", bus.err_oob, exp_err); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cam_burst();
        test_draw();
        test_clear_full();
        test_clear_cam_stall();
        test_draw_and_start();
        test_reset_mid_fill();
        test_oob();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
